// File: rtl/riscv32ima_fetch_queue_if.sv
// Fetch-queue bus bundle: decode-side handshake, PC write-back and the
// instruction-memory request/response signals.
//   master : the fetch queue (drives fetch_*, i_ncs/i_nwe/i_addr/i_wdata/i_wmask)
//   slave  : the environment (drives fetch_ready, wback_*, i_rdata, i_stall)
interface riscv32ima_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int INSN_WIDTH = 32
);
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [INSN_WIDTH-1:0] fetch_data;
  logic                  wback_pc_wen;
  logic [ADDR_WIDTH-1:0] wback_pc;
  logic                  i_ncs;
  logic                  i_nwe;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0] i_wmask;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_stall;

  modport master (
    output fetch_valid, fetch_address, fetch_data,
    output i_ncs, i_nwe, i_addr, i_wdata, i_wmask,
    input  fetch_ready, wback_pc_wen, wback_pc, i_rdata, i_stall
  );

  modport slave (
    input  fetch_valid, fetch_address, fetch_data,
    input  i_ncs, i_nwe, i_addr, i_wdata, i_wmask,
    output fetch_ready, wback_pc_wen, wback_pc, i_rdata, i_stall
  );
endinterface

// File: rtl/riscv32ima_fetch_queue.sv
// Instruction-fetch front end with a prefetch queue.
// Reads DATA_WIDTH lines from instruction memory, splits them into LANES
// instruction slots and queues each slot with its PC; decode pops one entry
// per fetch_valid/fetch_ready handshake. A PC write-back flushes and redirects.
// Ports:
//   clk   rising-edge clock
//   nrst  asynchronous active-low reset
//   bus   riscv32ima_fetch_queue_if.master
//         fetch_valid/fetch_ready/fetch_address/fetch_data : decode handshake
//         wback_pc_wen/wback_pc                            : redirect
//         i_ncs/i_nwe/i_addr/i_wdata/i_wmask/i_rdata/i_stall : memory port
module riscv32ima_fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    INSN_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       nrst,
  riscv32ima_fetch_queue_if.master   bus
);

  localparam int LANES   = DATA_WIDTH / INSN_WIDTH;
  localparam int LINE_B  = DATA_WIDTH / 8;
  localparam int INSN_B  = INSN_WIDTH / 8;
  localparam int INSN_SH = $clog2(INSN_B);
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int UW      = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_B - 1));

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_WAIT} state_t;

  // Slot index of a byte address within its memory line.
  function automatic logic [LANE_W-1:0] slot_of(input logic [ADDR_WIDTH-1:0] a);
    return LANE_W'((a >> INSN_SH) & ADDR_WIDTH'(LANES - 1));
  endfunction

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LANE_W-1:0]     r_skip;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_addr;
  logic [LANE_W-1:0]     r_inflight_skip;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [INSN_WIDTH-1:0] r_q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc   [QUEUE_DEPTH];

  logic                  w_redirect;
  logic [ADDR_WIDTH-1:0] w_redirect_addr;
  logic [LANE_W-1:0]     w_redirect_skip;
  logic [UW-1:0]         w_used, w_push_n, w_count_next, w_used_next;
  logic                  w_req, w_accept, w_pop, w_capture;
  logic [PTR_W-1:0]      w_lane_idx [LANES];
  logic                  w_lane_en  [LANES];

  assign w_redirect      = bus.wback_pc_wen;
  assign w_redirect_addr = bus.wback_pc & LINE_MASK;
  assign w_redirect_skip = slot_of(bus.wback_pc);

  // Queue slots already spoken for: stored entries plus a whole line reserved
  // for the response still on its way.
  assign w_used   = UW'(r_count) + (r_inflight ? UW'(LANES) : UW'(0));
  // A redirect withdraws any request in the same cycle, so a stale line is
  // never accepted while the new target is being loaded.
  assign w_req    = (r_state == ST_FETCH) && !w_redirect &&
                    ((w_used + UW'(LANES)) <= UW'(QUEUE_DEPTH));
  assign w_accept = w_req && !bus.i_stall;
  assign w_pop    = (r_count != '0) && bus.fetch_ready;
  // Response data is valid exactly one cycle after accept; a redirect in that
  // cycle discards it.
  assign w_capture = r_inflight && !w_redirect;
  assign w_push_n  = w_capture ? (UW'(LANES) - UW'(r_inflight_skip)) : UW'(0);
  assign w_count_next = UW'(r_count) + w_push_n - (w_pop ? UW'(1) : UW'(0));
  assign w_used_next  = w_count_next + (w_accept ? UW'(LANES) : UW'(0));

  // Next-state uses next-cycle credit so a freed slot is usable without a bubble.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_BOOT:  w_state_next = ST_FETCH;
      ST_FETCH: if ((w_used_next + UW'(LANES)) > UW'(QUEUE_DEPTH)) w_state_next = ST_WAIT;
      ST_WAIT:  if ((w_used_next + UW'(LANES)) <= UW'(QUEUE_DEPTH)) w_state_next = ST_FETCH;
      default:  w_state_next = ST_BOOT;
    endcase
    if (w_redirect) w_state_next = ST_FETCH;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_idx[l] = r_wr_ptr + PTR_W'(l) - PTR_W'(r_inflight_skip);
      w_lane_en[l]  = w_capture && (LANE_W'(l) >= r_inflight_skip);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_BOOT;
    else       r_state <= w_state_next;
  end

  // Request / queue control
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_addr     <= RESET_PC & LINE_MASK;
      r_skip     <= slot_of(RESET_PC);
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (w_redirect) begin
      r_addr     <= w_redirect_addr;
      r_skip     <= w_redirect_skip;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_addr <= r_addr + ADDR_WIDTH'(LINE_B);
        r_skip <= '0;
      end
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= CNT_W'(w_count_next);
    end
  end

  // Response capture: lane 0 holds the lowest address
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_inflight_addr <= r_addr;
      r_inflight_skip <= r_skip;
    end
    for (int l = 0; l < LANES; l++) begin
      if (w_lane_en[l]) begin
        r_q_data[w_lane_idx[l]] <= bus.i_rdata[l*INSN_WIDTH +: INSN_WIDTH];
        r_q_pc[w_lane_idx[l]]   <= r_inflight_addr + ADDR_WIDTH'(l * INSN_B);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) assert (UW'(r_count) <= UW'(QUEUE_DEPTH));
  end

  assign bus.fetch_valid   = (r_count != '0);
  assign bus.fetch_address = r_q_pc[r_rd_ptr];
  assign bus.fetch_data    = r_q_data[r_rd_ptr];
  assign bus.i_ncs         = !w_req;
  assign bus.i_nwe         = 1'b1;
  assign bus.i_addr        = r_addr;
  assign bus.i_wdata       = '0;
  assign bus.i_wmask       = '0;

endmodule

// File: tb/tb_riscv32ima_fetch_queue.sv
module tb_riscv32ima_fetch_queue;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 32;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  riscv32ima_fetch_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSN_WIDTH(IW)) bus ();

  riscv32ima_fetch_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSN_WIDTH(IW),
    .QUEUE_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] insn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // Instruction memory: line returned one cycle after an accepted request.
  always @(posedge clk) begin
    if (!bus.i_ncs && !bus.i_stall) bus.i_rdata <= {insn(bus.i_addr + 32'd4), insn(bus.i_addr)};
    else                            bus.i_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    bus.fetch_ready = 1'b0; bus.wback_pc_wen = 1'b0; bus.wback_pc = '0; bus.i_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  // Pops entries (recording PC and data) until n are collected or the budget runs out.
  task automatic collect_pops(input int n, input int max_cycles, input bit rnd);
    got_pc.delete(); got_data.delete();
    for (int c = 0; c < max_cycles && got_pc.size() < n; c++) begin
      bus.fetch_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.fetch_valid && bus.fetch_ready) begin
        got_pc.push_back(bus.fetch_address);
        got_data.push_back(bus.fetch_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.fetch_ready = 1'b1; bus.wback_pc_wen = 1'b0; bus.wback_pc = '0; bus.i_stall = 1'b0;
    tick();
    vectors++; if (bus.fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset fetch_valid: got %b want 0", bus.fetch_valid); end
    vectors++; if (bus.i_ncs !== 1'b1) begin miscompares++; $display("FAIL reset i_ncs: got %b want 1", bus.i_ncs); end
    vectors++; if (bus.i_nwe !== 1'b1) begin miscompares++; $display("FAIL reset i_nwe: got %b want 1", bus.i_nwe); end
    vectors++; if (bus.i_addr !== 32'h0) begin miscompares++; $display("FAIL reset i_addr: got %h want 0", bus.i_addr); end
    vectors++; if (bus.i_wdata !== 64'h0 || bus.i_wmask !== 64'h0) begin
      miscompares++; $display("FAIL reset wdata/wmask: got %h/%h want 0/0", bus.i_wdata, bus.i_wmask); end
  endtask

  task automatic test_basic_stream();
    apply_reset();
    bus.fetch_ready = 1'b1;
    vectors++; if (bus.i_ncs !== 1'b1) begin miscompares++; $display("FAIL boot i_ncs cycle0: got %b want 1", bus.i_ncs); end
    tick();
    vectors++; if (bus.i_ncs !== 1'b0 || bus.i_addr !== 32'h0) begin
      miscompares++; $display("FAIL first request cycle1: got ncs=%b addr=%h want ncs=0 addr=0", bus.i_ncs, bus.i_addr); end
    tick();
    vectors++; if (bus.i_ncs !== 1'b0 || bus.i_addr !== 32'h8) begin
      miscompares++; $display("FAIL back-to-back request cycle2: got ncs=%b addr=%h want ncs=0 addr=8", bus.i_ncs, bus.i_addr); end
    tick();
    vectors++; if (bus.fetch_valid !== 1'b1 || bus.fetch_address !== 32'h0 || bus.fetch_data !== insn(32'h0)) begin
      miscompares++; $display("FAIL first output cycle3: got v=%b pc=%h d=%h want v=1 pc=0 d=%h",
                              bus.fetch_valid, bus.fetch_address, bus.fetch_data, insn(32'h0)); end
    tick();
    collect_pops(7, 40, 1'b0);
    vectors++; if (got_pc.size() != 7) begin miscompares++; $display("FAIL basic pop count: got %0d want 7", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(4 * (i + 1)) || got_data[i] !== insn(32'(4 * (i + 1)))) begin
        miscompares++; $display("FAIL basic stream[%0d]: got pc=%h d=%h want pc=%h d=%h",
                                i, got_pc[i], got_data[i], 32'(4 * (i + 1)), insn(32'(4 * (i + 1)))); end
    end
    vectors++; if (bus.i_nwe !== 1'b1) begin miscompares++; $display("FAIL basic i_nwe: got %b want 1", bus.i_nwe); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int head_bad = 0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      #1;
      if (!bus.i_ncs && !bus.i_stall) accepted++;
      if (bus.fetch_valid && (bus.fetch_address !== 32'h0 || bus.fetch_data !== insn(32'h0))) head_bad++;
      tick();
    end
    vectors++; if (accepted != 2) begin miscompares++; $display("FAIL backpressure lines fetched: got %0d want 2", accepted); end
    vectors++; if (bus.i_ncs !== 1'b1) begin miscompares++; $display("FAIL backpressure idle i_ncs: got %b want 1", bus.i_ncs); end
    vectors++; if (bus.fetch_valid !== 1'b1 || head_bad != 0) begin
      miscompares++; $display("FAIL backpressure head hold: got v=%b unstable=%0d want v=1 unstable=0", bus.fetch_valid, head_bad); end
    collect_pops(8, 40, 1'b0);
    vectors++; if (got_pc.size() != 8) begin miscompares++; $display("FAIL resume pop count: got %0d want 8", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(4 * i) || got_data[i] !== insn(32'(4 * i))) begin
        miscompares++; $display("FAIL resume stream[%0d]: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    int stalls = 0;
    int acc8 = -1;
    int pop8 = -1;
    apply_reset();
    bus.fetch_ready = 1'b1;
    got_pc.delete(); got_data.delete();
    for (int c = 0; c < 40 && got_pc.size() < 8; c++) begin
      if (stalls > 0 && stalls < 3) begin
        vectors++;
        if (bus.i_ncs !== 1'b0 || bus.i_addr !== 32'h8) begin
          miscompares++; $display("FAIL stall hold: got ncs=%b addr=%h want ncs=0 addr=8", bus.i_ncs, bus.i_addr); end
        bus.i_stall = 1'b1; stalls++;
      end else if (stalls == 0 && !bus.i_ncs && bus.i_addr == 32'h8) begin
        bus.i_stall = 1'b1; stalls++;
      end else bus.i_stall = 1'b0;
      #1;
      if (!bus.i_ncs && !bus.i_stall && bus.i_addr == 32'h8 && acc8 < 0) acc8 = c;
      if (bus.fetch_valid && bus.fetch_ready) begin
        got_pc.push_back(bus.fetch_address); got_data.push_back(bus.fetch_data);
        if (bus.fetch_address == 32'h8 && pop8 < 0) pop8 = c;
      end
      tick();
    end
    bus.i_stall = 1'b0;
    vectors++; if (stalls != 3) begin miscompares++; $display("FAIL stall cycles applied: got %0d want 3", stalls); end
    vectors++; if (acc8 < 0 || pop8 < acc8 + 2) begin
      miscompares++; $display("FAIL stall consume timing: got accept=%0d pop=%0d want pop>=accept+2", acc8, pop8); end
    vectors++; if (got_pc.size() != 8) begin miscompares++; $display("FAIL stall pop count: got %0d want 8", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(4 * i) || got_data[i] !== insn(32'(4 * i))) begin
        miscompares++; $display("FAIL stall stream[%0d]: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    apply_reset();
    bus.fetch_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      #1;
      if (!bus.i_ncs && !bus.i_stall && bus.i_addr == 32'h10) found = 1;
      tick();
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL redirect setup: request at 0x10 not seen"); end
    bus.wback_pc_wen = 1'b1; bus.wback_pc = 32'h104;
    tick();
    bus.wback_pc_wen = 1'b0; bus.fetch_ready = 1'b0;
    vectors++; if (bus.fetch_valid !== 1'b0) begin miscompares++; $display("FAIL redirect flush: got v=%b want 0", bus.fetch_valid); end
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (!bus.i_ncs) found = 1;
      else tick();
    end
    vectors++; if (!found || bus.i_addr !== 32'h100) begin
      miscompares++; $display("FAIL redirect request: got seen=%0d addr=%h want seen=1 addr=100", found, bus.i_addr); end
    collect_pops(3, 30, 1'b0);
    vectors++; if (got_pc.size() != 3) begin miscompares++; $display("FAIL redirect pop count: got %0d want 3", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(32'h104 + 4 * i) || got_data[i] !== insn(32'(32'h104 + 4 * i))) begin
        miscompares++; $display("FAIL redirect stream[%0d]: got pc=%h d=%h want pc=%h", i, got_pc[i], got_data[i], 32'(32'h104 + 4 * i)); end
    end
  endtask

  task automatic test_back_to_back_redirect();
    bus.fetch_ready = 1'b0;
    bus.wback_pc_wen = 1'b1; bus.wback_pc = 32'h200;
    tick();
    bus.wback_pc = 32'h30C;
    tick();
    bus.wback_pc_wen = 1'b0;
    collect_pops(2, 30, 1'b0);
    vectors++; if (got_pc.size() != 2) begin miscompares++; $display("FAIL b2b redirect pop count: got %0d want 2", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(32'h30C + 4 * i) || got_data[i] !== insn(32'(32'h30C + 4 * i))) begin
        miscompares++; $display("FAIL b2b redirect stream[%0d]: got pc=%h want pc=%h", i, got_pc[i], 32'(32'h30C + 4 * i)); end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    tick(); tick(); tick();
    vectors++; if (bus.fetch_valid !== 1'b1 || bus.i_addr !== 32'h10) begin
      miscompares++; $display("FAIL midflight setup: got v=%b addr=%h want v=1 addr=10", bus.fetch_valid, bus.i_addr); end
    nrst = 1'b0;
    #1;
    vectors++; if (bus.fetch_valid !== 1'b0 || bus.i_ncs !== 1'b1 || bus.i_addr !== 32'h0) begin
      miscompares++; $display("FAIL async reset outputs: got v=%b ncs=%b addr=%h want v=0 ncs=1 addr=0",
                              bus.fetch_valid, bus.i_ncs, bus.i_addr); end
    @(posedge clk); #1 nrst = 1'b1;
    collect_pops(4, 40, 1'b0);
    vectors++; if (got_pc.size() != 4) begin miscompares++; $display("FAIL restart pop count: got %0d want 4", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(4 * i) || got_data[i] !== insn(32'(4 * i))) begin
        miscompares++; $display("FAIL restart stream[%0d]: got pc=%h want pc=%h", i, got_pc[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap_random();
    apply_reset();
    collect_pops(64, 2000, 1'b1);
    vectors++; if (got_pc.size() != 64) begin miscompares++; $display("FAIL wrap pop count: got %0d want 64", got_pc.size()); end
    foreach (got_pc[i]) begin
      vectors++;
      if (got_pc[i] !== 32'(4 * i) || got_data[i] !== insn(32'(4 * i))) begin
        miscompares++; $display("FAIL wrap stream[%0d]: got pc=%h d=%h want pc=%h d=%h",
                                i, got_pc[i], got_data[i], 32'(4 * i), insn(32'(4 * i))); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_stall();
    test_redirect();
    test_back_to_back_redirect();
    test_reset_midflight();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
